// File: rtl/uart_rx_sampler.sv
// 8N1 oversampling UART receiver: 2-flop synchroniser, 16x tick generator,
// 3-sample majority vote per bit, false-start rejection and framing-error strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, counters held at 0, waiting for rxs low
// ST_START | start bit: reject at mid-bit if majority is high
// ST_DATA  | eight data bits, LSB first, shifted in from the MSB side
// ST_STOP  | stop bit: majority high -> byte out, low -> framing error
// ST_BREAK | line held low after a framing error, wait for rxs high
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dat,
    output logic       dat_en,
    output logic       frame_err,
    output logic       busy
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0] S_FIRST = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_SECOND = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] S_THIRD = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rxs;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [3:0]    s_cnt, s_nxt;
    logic          samp_a, samp_a_nxt;
    logic          samp_b, samp_b_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    dat_nxt;
    logic          dat_en_nxt, frame_err_nxt;
    logic          tick, mid_tick, end_tick, maj;

    assign tick     = (div_cnt == DIV_LAST);
    assign mid_tick = tick && (s_cnt == S_THIRD);
    assign end_tick = tick && (s_cnt == S_LAST);
    // third vote is the live sample taken on the deciding tick
    assign maj      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign busy     = (state != ST_IDLE) | dat_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= ST_IDLE;
            div_cnt   <= '0;
            s_cnt     <= '0;
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '0;
            dat       <= '0;
            dat_en    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            s_cnt     <= s_nxt;
            samp_a    <= samp_a_nxt;
            samp_b    <= samp_b_nxt;
            bit_idx   <= bit_nxt;
            shreg     <= shreg_nxt;
            dat       <= dat_nxt;
            dat_en    <= dat_en_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = tick ? '0 : div_cnt + 1'b1;
        s_nxt         = tick ? s_cnt + 4'd1 : s_cnt;
        samp_a_nxt    = (tick && s_cnt == S_FIRST) ? rxs : samp_a;
        samp_b_nxt    = (tick && s_cnt == S_SECOND) ? rxs : samp_b;
        bit_nxt       = bit_idx;
        shreg_nxt     = shreg;
        dat_nxt       = dat;
        dat_en_nxt    = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                div_nxt = '0;
                s_nxt   = '0;
                if (!rxs) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (mid_tick && maj) begin
                    state_nxt = ST_IDLE;
                end else if (end_tick) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (mid_tick) begin
                    shreg_nxt = {maj, shreg[7:1]};
                end
                if (end_tick) begin
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // decide at mid-stop so a following start bit is not missed
                if (mid_tick) begin
                    if (maj) begin
                        dat_nxt    = shreg;
                        dat_en_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                div_nxt = '0;
                s_nxt   = '0;
                if (rxs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 100 MHz / 115200 baud (868 clocks per line bit).
module tb_uart_rx_sampler;

    localparam int BIT = 868;
    localparam int SPK = 54;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dat;
    logic       dat_en;
    logic       frame_err;
    logic       busy;

    uart_rx_sampler #(
        .CLK_FREQ(100000000),
        .BAUD(115200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .dat(dat),
        .dat_en(dat_en),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int last_en_cyc = -1;
    logic [7:0] rx_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // strobes are counted per high cycle, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (dat_en === 1'b1) begin
            en_cnt++;
            last_en_cyc = cyc;
            rx_log.push_back(dat);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (dat_en === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] log_at(input int k);
        return (rx_log.size() > k) ? {24'h0, rx_log[k]} : 32'hDEAD;
    endfunction

    // one frame, one line bit per BIT clocks; optional flipped spike in a data bit
    // and optional one-cycle reset at a given clock offset into the frame
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits,
                              input int spike_bit, input int rst_at, output int t_start);
        int total;
        int pos;
        int off;
        logic v;
        total = (9 + stop_bits) * BIT;
        t_start = cyc;
        for (int i = 0; i < total; i++) begin
            pos = i / BIT;
            off = i % BIT;
            if (pos == 0) v = 1'b0;
            else if (pos <= 8) v = b[pos-1];
            else v = stop_val;
            if (pos - 1 == spike_bit && off >= (BIT - SPK) / 2 && off < (BIT + SPK) / 2) v = ~v;
            rx = v;
            rst = (i != rst_at);
            step(1);
        end
        rst = 1'b1;
    endtask

    initial begin
        int t0;
        int lat;
        int base;
        int fbase;

        // reset held with the line toggling
        rst = 1'b0;
        rx = 1'b1;
        step(2);
        for (int i = 0; i < 16; i++) begin
            rx = (i % 3 == 0) ? 1'b0 : 1'b1;
            step(1);
            check("reset_hold", {21'h0, dat, dat_en, frame_err, busy}, 32'h0);
        end
        rx = 1'b1;
        step(3);
        rst = 1'b1;
        step(20);
        check("idle_busy", busy, 0);
        check("idle_dat", dat, 8'h00);

        // single frame 0xA5 with latency
        base = en_cnt;
        send_frame(8'hA5, 1'b1, 1, -1, -1, t0);
        step(200);
        lat = last_en_cyc - t0;
        check("a5_count", en_cnt - base, 1);
        check("a5_dat", dat, 8'hA5);
        check("a5_latency", (lat >= 8318 && lat <= 8320) ? 8319 : lat, 8319);
        check("a5_no_fe", fe_cnt, 0);
        check("a5_busy_after", busy, 0);

        // back-to-back frames, no idle gap
        base = en_cnt;
        send_frame(8'h00, 1'b1, 1, -1, -1, t0);
        send_frame(8'hFF, 1'b1, 1, -1, -1, t0);
        send_frame(8'h3C, 1'b1, 1, -1, -1, t0);
        step(200);
        check("b2b_count", en_cnt - base, 3);
        check("b2b_dat0", log_at(base), 8'h00);
        check("b2b_dat1", log_at(base + 1), 8'hFF);
        check("b2b_dat2", log_at(base + 2), 8'h3C);
        check("b2b_no_fe", fe_cnt, 0);

        // 200-cycle glitch is shorter than the mid-bit sample point
        base = en_cnt;
        rx = 1'b0;
        step(100);
        check("glitch_busy_mid", busy, 1);
        step(100);
        rx = 1'b1;
        step(1000);
        check("glitch_no_dat", en_cnt - base, 0);
        check("glitch_no_fe", fe_cnt, 0);
        check("glitch_busy_after", busy, 0);
        check("glitch_dat_kept", dat, 8'h3C);

        // DIV-wide high spike in the middle of data bit 1 is outvoted
        base = en_cnt;
        send_frame(8'h81, 1'b1, 1, 1, -1, t0);
        step(200);
        check("maj_count", en_cnt - base, 1);
        check("maj_dat", dat, 8'h81);

        // framing error: stop held low for three bit times
        base = en_cnt;
        fbase = fe_cnt;
        send_frame(8'h55, 1'b0, 3, -1, -1, t0);
        check("fe_pulse", fe_cnt - fbase, 1);
        check("fe_no_dat", en_cnt - base, 0);
        check("fe_dat_kept", dat, 8'h81);
        check("fe_busy_break", busy, 1);
        rx = 1'b1;
        step(1);
        check("fe_busy_sync", busy, 1);
        step(4);
        check("fe_busy_released", busy, 0);
        step(500);

        // reset late in data bit 7 of 0x12 aborts the frame
        base = en_cnt;
        fbase = fe_cnt;
        send_frame(8'h12, 1'b1, 1, -1, 8 * BIT + 651, t0);
        step(300);
        check("rst_no_dat", en_cnt - base, 0);
        check("rst_no_fe", fe_cnt - fbase, 0);
        check("rst_dat_cleared", dat, 8'h00);
        check("rst_busy", busy, 0);
        step(500);
        send_frame(8'h34, 1'b1, 1, -1, -1, t0);
        step(200);
        check("post_rst_count", en_cnt - base, 1);
        check("post_rst_dat", dat, 8'h34);

        check("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
